rfft_unload: RTL and testbench

Result unloader for the 256-point RFFT core. Once the butterfly pipeline has finished, it reads the 256 result words from the four 64-deep result banks. It maps natural output order onto bank and address, undoing the bit-reversal, and streams the words out over a valid/ready interface with full backpressure. It sits between the bank read ports and the downstream consumer, and is triggered by the core's done pulse.

---
 rtl/rfft_unload.sv | 178 +++++++++++++++++
 tb/tb_rfft_unload.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rfft_unload.sv
// rtl/rfft_unload.sv - result unloader for the 256-point RFFT core
//
// Reads the 256 result words out of the four 64-deep result banks after the
// butterfly pipeline completes and streams them in natural index order.
//
// Parameters
//   WIDTH     data word width
//   BITREV    1: fetch address is bitrev8(k) so words leave in natural order
//             0: fetch address is k (storage order)
//
// Ports
//   Clk                  clock, rising edge
//   Reset_n              synchronous active-low reset
//   start                one-cycle unload request, ignored while busy
//   busy                 unload in progress
//   rd_en[3:0]           one-hot bank read enable
//   rd_addr[5:0]         shared bank read address
//   rd_data0..rd_data3   bank read data, one cycle after rd_en/rd_addr
//   out_data             result word
//   out_index[7:0]       natural index of out_data
//   out_valid            out_data/out_index/out_last valid
//   out_ready            consumer ready
//   out_last             high with the index-255 word
//   finished             one-cycle pulse after the final pop

module rfft_unload #(
    parameter int WIDTH  = 32,
    parameter bit BITREV = 1'b1
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             start,
    output logic             busy,
    output logic [3:0]       rd_en,
    output logic [5:0]       rd_addr,
    input  logic [WIDTH-1:0] rd_data0,
    input  logic [WIDTH-1:0] rd_data1,
    input  logic [WIDTH-1:0] rd_data2,
    input  logic [WIDTH-1:0] rd_data3,
    output logic [WIDTH-1:0] out_data,
    output logic [7:0]       out_index,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             finished
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t state;

    // Issue counter: natural index of the next word to fetch.
    logic [7:0] k;
    logic [7:0] k_rev;
    logic [7:0] p;

    // One read may be in flight; its bank select and index travel with it
    // so the returning word can be steered and tagged a cycle later.
    logic       inflight;
    logic [1:0] inflight_bank;
    logic [7:0] inflight_k;

    // Two-entry output buffer.
    logic [WIDTH-1:0] fifo_data [2];
    logic [7:0]       fifo_idx  [2];
    logic             head;
    logic             tail;
    logic [1:0]       fifo_count;

    logic             pop;
    logic             push;
    logic             issue;
    logic [2:0]       occupancy;
    logic [WIDTH-1:0] ret_data;

    assign k_rev = {k[0], k[1], k[2], k[3], k[4], k[5], k[6], k[7]};
    assign p     = BITREV ? k_rev : k;

    assign out_valid = (fifo_count != 2'd0);
    assign pop       = out_valid & out_ready;
    assign push      = inflight;

    // Space reserved for words already buffered or on their way back; a pop
    // this cycle frees one slot, which keeps the stream at one word per cycle.
    assign occupancy = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
    assign issue     = (state == S_RUN) && (occupancy < 3'd2);

    assign rd_en   = issue ? (4'b0001 << p[7:6]) : 4'b0000;
    assign rd_addr = issue ? p[5:0] : 6'd0;

    always_comb begin
        ret_data = rd_data0;
        unique case (inflight_bank)
            2'd0:    ret_data = rd_data0;
            2'd1:    ret_data = rd_data1;
            2'd2:    ret_data = rd_data2;
            2'd3:    ret_data = rd_data3;
            default: ret_data = rd_data0;
        endcase
    end

    assign out_data  = fifo_data[head];
    assign out_index = fifo_idx[head];
    assign out_last  = out_valid && (fifo_idx[head] == 8'd255);
    assign busy      = (state != S_IDLE);

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state         <= S_IDLE;
            k             <= 8'd0;
            inflight      <= 1'b0;
            inflight_bank <= 2'd0;
            inflight_k    <= 8'd0;
            head          <= 1'b0;
            tail          <= 1'b0;
            fifo_count    <= 2'd0;
            finished      <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                fifo_data[i] <= '0;
                fifo_idx[i]  <= 8'd0;
            end
        end else begin
            finished <= 1'b0;

            inflight <= issue;
            if (issue) begin
                inflight_bank <= p[7:6];
                inflight_k    <= k;
            end

            if (push) begin
                fifo_data[tail] <= ret_data;
                fifo_idx[tail]  <= inflight_k;
                tail            <= ~tail;
            end
            if (pop) begin
                head <= ~head;
            end
            fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};

            unique case (state)
                S_IDLE: begin
                    // Buffer is already empty here; clearing it keeps every
                    // unload starting from a known pointer state.
                    if (start) begin
                        state      <= S_RUN;
                        k          <= 8'd0;
                        head       <= 1'b0;
                        tail       <= 1'b0;
                        fifo_count <= 2'd0;
                    end
                end
                S_RUN: begin
                    if (issue) begin
                        k <= k + 8'd1;
                        if (k == 8'd255) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (pop && (fifo_idx[head] == 8'd255)) begin
                        state    <= S_IDLE;
                        finished <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rfft_unload.sv
// tb/tb_rfft_unload.sv - self-checking bench for rfft_unload

module tb_rfft_unload;

    localparam int W = 32;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic Reset_n;
    logic start;
    logic out_ready;

    // Index 0: BITREV=1 instance, index 1: BITREV=0 instance.
    logic         busy_w      [2];
    logic [3:0]   rd_en_w     [2];
    logic [5:0]   rd_addr_w   [2];
    logic [W-1:0] rd_data_w   [2][4];
    logic [W-1:0] out_data_w  [2];
    logic [7:0]   out_index_w [2];
    logic         out_valid_w [2];
    logic         out_last_w  [2];
    logic         finished_w  [2];

    rfft_unload #(.WIDTH(W), .BITREV(1'b1)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .start(start), .busy(busy_w[0]),
        .rd_en(rd_en_w[0]), .rd_addr(rd_addr_w[0]),
        .rd_data0(rd_data_w[0][0]), .rd_data1(rd_data_w[0][1]),
        .rd_data2(rd_data_w[0][2]), .rd_data3(rd_data_w[0][3]),
        .out_data(out_data_w[0]), .out_index(out_index_w[0]),
        .out_valid(out_valid_w[0]), .out_ready(out_ready),
        .out_last(out_last_w[0]), .finished(finished_w[0])
    );

    rfft_unload #(.WIDTH(W), .BITREV(1'b0)) dut_lin (
        .Clk(Clk), .Reset_n(Reset_n), .start(start), .busy(busy_w[1]),
        .rd_en(rd_en_w[1]), .rd_addr(rd_addr_w[1]),
        .rd_data0(rd_data_w[1][0]), .rd_data1(rd_data_w[1][1]),
        .rd_data2(rd_data_w[1][2]), .rd_data3(rd_data_w[1][3]),
        .out_data(out_data_w[1]), .out_index(out_index_w[1]),
        .out_valid(out_valid_w[1]), .out_ready(out_ready),
        .out_last(out_last_w[1]), .finished(finished_w[1])
    );

    // Result banks; data is only meaningful one cycle after its read enable,
    // otherwise the bus carries noise.
    logic [W-1:0] bank_mem [4][64];

    always @(posedge Clk) begin
        for (int i = 0; i < 2; i++) begin
            for (int b = 0; b < 4; b++) begin
                rd_data_w[i][b] <= rd_en_w[i][b] ? bank_mem[b][rd_addr_w[i]] : W'($urandom());
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    // Storage location of natural index k for each instance.
    function automatic logic [7:0] loc(input int inst, input int k);
        logic [7:0] kk;
        kk = k[7:0];
        return (inst == 0) ? rev8(kk) : kk;
    endfunction

    function automatic logic [W-1:0] model_word(input int inst, input int k);
        logic [7:0] l;
        l = loc(inst, k);
        return bank_mem[l / 64][l % 64];
    endfunction

    // Reference state.
    int           exp_k    [2];
    int           issued   [2];
    int           pops     [2];
    int           fin_cnt  [2];
    logic         stalled  [2];
    logic [W-1:0] held_data[2];
    logic [7:0]   held_idx [2];
    int           cyc;
    int           first_valid_cyc;
    int           last_cyc;
    int           fin_cyc;
    int           pop_cyc  [256];
    logic [7:0]   fetch_tbl[5];

    task automatic clear_model();
        for (int i = 0; i < 2; i++) begin
            exp_k[i]   = 0;
            issued[i]  = 0;
            pops[i]    = 0;
            fin_cnt[i] = 0;
            stalled[i] = 1'b0;
        end
        cyc             = 0;
        first_valid_cyc = -1;
        last_cyc        = -1;
        fin_cyc         = -1;
    endtask

    task automatic observe();
        logic [7:0] l;
        logic       popped;
        for (int i = 0; i < 2; i++) begin
            check("rd_en_onehot", 64'($onehot0(rd_en_w[i])), 1);
            if (!busy_w[i]) check("rd_en_idle", rd_en_w[i], 0);
            if (cyc == 0) check("busy_c0", busy_w[i], 0);
            if (cyc == 1) check("busy_c1", busy_w[i], 1);
            if (rd_en_w[i] != 4'd0) begin
                l = loc(i, issued[i]);
                check("rd_en", rd_en_w[i], 4'b0001 << (l / 64));
                check("rd_addr", rd_addr_w[i], l % 64);
                issued[i]++;
            end
            if (stalled[i]) begin
                check("hold_valid", out_valid_w[i], 1);
                check("hold_data", out_data_w[i], held_data[i]);
                check("hold_index", out_index_w[i], held_idx[i]);
            end
            if (out_valid_w[i] && i == 0 && first_valid_cyc < 0) first_valid_cyc = cyc;
            popped = out_valid_w[i] & out_ready;
            if (popped) begin
                if (exp_k[i] > 255) begin
                    check("extra_pop", 1, 0);
                end else begin
                    check("out_index", out_index_w[i], exp_k[i]);
                    check("out_data", out_data_w[i], model_word(i, exp_k[i]));
                    check("out_last", out_last_w[i], exp_k[i] == 255);
                    if (i == 0 && exp_k[i] < 5)
                        check("bitrev_fetch", out_data_w[i][7:0], fetch_tbl[exp_k[i]]);
                    if (i == 1 && exp_k[i] == 100)
                        check("linear_k100", out_data_w[i][7:0], {2'd1, 6'd36});
                    if (i == 0) pop_cyc[exp_k[i]] = cyc;
                    if (i == 0 && out_last_w[i]) last_cyc = cyc;
                end
                exp_k[i]++;
                pops[i]++;
            end
            check("occupancy", (issued[i] - pops[i]) <= 2, 1);
            if (finished_w[i]) begin
                fin_cnt[i]++;
                check("fin_pops", pops[i], 256);
                check("fin_busy", busy_w[i], 0);
                if (i == 0) fin_cyc = cyc;
            end
            stalled[i]   = out_valid_w[i] & ~out_ready;
            held_data[i] = out_data_w[i];
            held_idx[i]  = out_index_w[i];
        end
    endtask

    // Entered at a falling edge: drive inputs for this cycle, check it, advance.
    task automatic cycle(input logic st, input logic rdy);
        start     = st;
        out_ready = rdy;
        #1;
        observe();
        @(negedge Clk);
        cyc++;
    endtask

    task automatic check_zero(input string tag);
        for (int i = 0; i < 2; i++) begin
            check({tag, "_busy"}, busy_w[i], 0);
            check({tag, "_rd_en"}, rd_en_w[i], 0);
            check({tag, "_rd_addr"}, rd_addr_w[i], 0);
            check({tag, "_valid"}, out_valid_w[i], 0);
            check({tag, "_data"}, out_data_w[i], 0);
            check({tag, "_index"}, out_index_w[i], 0);
            check({tag, "_last"}, out_last_w[i], 0);
            check({tag, "_finished"}, finished_w[i], 0);
        end
    endtask

    // mode 0: ready high; 1: random ready; 2: ready low for cycles 0..20.
    task automatic run_unload(input int mode, input bit restart50, input bit reset120);
        bit   done;
        bit   restarted;
        logic st;
        logic rdy;
        done      = 1'b0;
        restarted = 1'b0;
        clear_model();
        cycle(1'b1, (mode == 2) ? 1'b0 : 1'b1);
        while (!done && cyc < 3000) begin
            rdy = 1'b1;
            if (mode == 1) rdy = 1'($urandom_range(0, 1));
            if (mode == 2 && cyc <= 20) rdy = 1'b0;
            if (mode == 2 && cyc == 20) begin
                check("stall_issued0", issued[0], 2);
                check("stall_issued1", issued[1], 2);
            end
            st = 1'b0;
            if (restart50 && !restarted && exp_k[0] == 50) begin
                st        = 1'b1;
                restarted = 1'b1;
            end
            if (reset120 && exp_k[0] == 120) begin
                Reset_n = 1'b0;
                cycle(1'b0, 1'b0);
                Reset_n   = 1'b1;
                start     = 1'b0;
                out_ready = 1'b0;
                #1;
                check_zero("after_reset");
                @(negedge Clk);
                return;
            end
            cycle(st, rdy);
            done = (fin_cnt[0] > 0) && (fin_cnt[1] > 0);
        end
        if (!done) check("timeout", 0, 1);
        repeat (5) cycle(1'b0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            check("fin_count", fin_cnt[i], 1);
            check("pop_total", pops[i], 256);
            check("issue_total", issued[i], 256);
        end
        if (mode == 0) begin
            check("first_valid_cycle", first_valid_cyc, 3);
            check("last_cycle", last_cyc, 258);
            check("finished_cycle", fin_cyc, 259);
        end
        if (mode == 2) begin
            check("release_k1", pop_cyc[1] - pop_cyc[0], 1);
            check("release_rate", pop_cyc[255] - pop_cyc[0], 255);
        end
    endtask

    initial begin
        logic [31:0] tmp;
        logic [7:0]  ba;
        fetch_tbl[0] = {2'd0, 6'd0};
        fetch_tbl[1] = {2'd2, 6'd0};
        fetch_tbl[2] = {2'd1, 6'd0};
        fetch_tbl[3] = {2'd3, 6'd0};
        fetch_tbl[4] = {2'd0, 6'd32};
        for (int b = 0; b < 4; b++) begin
            for (int a = 0; a < 64; a++) begin
                tmp = $urandom();
                ba  = 8'(b * 64 + a);
                bank_mem[b][a] = {tmp[23:0], ba};
            end
        end
        Reset_n   = 1'b0;
        start     = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge Clk);
        #1;
        check_zero("reset");
        Reset_n = 1'b1;
        @(negedge Clk);

        run_unload(0, 1'b0, 1'b0);
        run_unload(1, 1'b0, 1'b0);
        run_unload(2, 1'b0, 1'b0);
        run_unload(0, 1'b1, 1'b0);
        run_unload(0, 1'b0, 1'b1);
        run_unload(0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
